dcache_ctrl_fsm: RTL and testbench
==================================

// Module: dcache_ctrl_fsm
// PURPOSE
// Parametrised data-cache control FSM; generational successor of the 2-word-block controller.
// Sits between the dcache datapath and the coherence/memory interface.
// Sequences miss fills, dirty write-backs and snoop write-backs over BLKWORDS-word blocks.
// Sequences end-of-program flush over FLUSHLINES frames, then halts.
// Drives a word index, and last-word/fill-done strobes, so the datapath needs no word logic of its own.
// PARAMETERS
// BLKWORDS    2   words per cache block (power of 2, >=2); burst length of every read/write
// FLUSHLINES  16  frames walked during flush; flctout==FLUSHLINES ends the flush
// WIDX        $clog2(BLKWORDS)        width of word_idx
// CTW         $clog2(FLUSHLINES+1)    width of flctout
// PORTS
// CLK        in   1     clock, rising edge
// nRST       in   1     asynchronous reset, active low
// dirty      in   1     selected frame (victim or flush frame) is valid and dirty
// dhit       in   1     current access hits
// dwait      in   1     memory busy; a word transfers in a cycle where dwait=0
// dmemREN    in   1     datapath read request
// dmemWEN    in   1     datapath write request
// flush      in   1     datapath halt/flush request (level)
// ccwait     in   1     coherence controller holds this cache
// ccwrite    in   1     with ccwait: snoop demands write-back of snooped block
// flctout    in   CTW   current flush frame index (owned by datapath counter)
// dREN       out  1     memory read strobe
// dWEN       out  1     memory write strobe
// word_idx   out  WIDX  word of block currently transferred
// last_word  out  1     word_idx==BLKWORDS-1 while dREN|dWEN
// invalid    out  1     last word of a write-back/snoop/flush burst; datapath clears dirty/valid
// fill_done  out  1     1-cycle pulse: final fill word accepted (dREN & last_word & ~dwait)
// flctup     out  1     advance flush counter
// flushing   out  1     in flush sequence
// idle       out  1     FSM in IDLE
// halt       out  1     flush complete, sticky until reset
// BEHAVIOUR
// - Moore outputs (except fill_done, which is also gated by ~dwait). Async reset -> IDLE, wcnt=0.
//   Reset values: idle=1, word_idx=0, all other outputs 0. Reset mid-burst aborts the burst cleanly.
// - States: IDLE, WB, READ, SNOOP, WAIT, FLSTART, FLUSH, FLCT, HALT.
// - wcnt: WIDX-bit word counter, drives word_idx; 0 outside bursts.
//   It clears on entry to WB/READ/SNOOP/FLUSH and increments when (dREN|dWEN)&~dwait.
// - miss = (dmemREN|dmemWEN) & ~dhit.
// - IDLE priority:
//   1) miss&~ccwait -> WB if dirty else READ;
//   2) else flush -> FLSTART;
//   3) else ccwait&ccwrite -> SNOOP;
//   4) else stay.
// - WB: dWEN=1. At last word with ~dwait -> READ (wcnt=0).
// - READ: dREN=1. At last word with ~dwait -> WAIT. Stall holds state and wcnt.
// - SNOOP: dWEN=1, invalid on last word. At last word with ~dwait -> WAIT.
// - WAIT: -> IDLE when ~ccwait, else hold.
// - FLSTART: flushing=1.
//   If flctout==FLUSHLINES -> HALT.
//   Else if dirty -> FLUSH, else -> FLCT.
// - FLUSH: flushing=1, dWEN=1, invalid on last word. At last word with ~dwait -> FLCT.
// - FLCT: flushing=1, flctup=1 for exactly one cycle -> FLSTART.
// - HALT: halt=1; absorbs all inputs until reset.
// - dREN and dWEN are never both 1. Any unencoded state -> IDLE.
// - dmemREN/WEN and flush are ignored outside IDLE; ccwait only gates IDLE and WAIT exits.
// TESTING
// 1. BLKWORDS=2, clean read miss (dirty=0, ccwait=0, dwait=0):
//    READ for 2 cycles, word_idx 0,1; fill_done on 2nd cycle; WAIT 1 cycle; idle next.
// 2. Dirty write miss with dwait=1 for 3 cycles on each word:
//    dWEN held, word_idx stable during stalls; invalid only on word 1; then READ 0,1.
// 3. Idle snoop (ccwait=1, ccwrite=1):
//    SNOOP writes 2 words; stays in WAIT until ccwait drops; miss with ccwait=1 is not taken.
// 4. FLUSHLINES=16, flush with dirty on frames 3 and 9 only:
//    exactly 16 flctup pulses, 4 dWEN words, halt=1 once flctout=16; halt sticky.
// 5. BLKWORDS=8: dirty miss gives 8 dWEN words, word_idx 0..7; then 8 dREN words; last_word only at idx 7.
// 6. nRST asserted at word 2 of an 8-word READ:
//    immediately idle=1, word_idx=0, dREN=0; a fresh miss restarts the burst at word 0.

Source files
------------

// File: rtl/dcache_ctrl_fsm.sv
// dcache_ctrl_fsm: data-cache control sequencer.
// Sequences miss fills, dirty write-backs, snoop write-backs and the end-of-program
// flush walk over BLKWORDS-word blocks, then halts. Supplies the word index and
// last-word/fill-done strobes so the datapath carries no word logic of its own.
// Ports:
//   CLK, nRST               clock (rising edge), asynchronous active-low reset
//   dirty, dhit             selected frame dirty+valid, current access hits
//   dwait                   memory busy; a word moves in a cycle with dwait=0
//   dmemREN, dmemWEN, flush datapath requests (sampled only in IDLE)
//   ccwait, ccwrite         coherence hold / snoop write-back demand
//   flctout                 current flush frame index from the datapath counter
//   dREN, dWEN              memory read/write strobes
//   word_idx, last_word     word of block in flight, final word of burst
//   invalid                 final word of a write burst; datapath clears dirty/valid
//   fill_done               final fill word accepted this cycle
//   flctup, flushing        advance flush counter, flush sequence active
//   idle, halt              FSM idle, flush complete (sticky)
module dcache_ctrl_fsm #(
  parameter int unsigned BLKWORDS   = 2,
  parameter int unsigned FLUSHLINES = 16,
  parameter int unsigned WIDX       = $clog2(BLKWORDS),
  parameter int unsigned CTW        = $clog2(FLUSHLINES + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            dirty,
  input  logic            dhit,
  input  logic            dwait,
  input  logic            dmemREN,
  input  logic            dmemWEN,
  input  logic            flush,
  input  logic            ccwait,
  input  logic            ccwrite,
  input  logic [CTW-1:0]  flctout,
  output logic            dREN,
  output logic            dWEN,
  output logic [WIDX-1:0] word_idx,
  output logic            last_word,
  output logic            invalid,
  output logic            fill_done,
  output logic            flctup,
  output logic            flushing,
  output logic            idle,
  output logic            halt
);

  localparam logic [WIDX-1:0] LAST_IDX = WIDX'(BLKWORDS - 1);
  localparam logic [CTW-1:0]  FL_END   = CTW'(FLUSHLINES);

  typedef enum logic [3:0] {
    IDLE, WB, READ, SNOOP, WAIT, FLSTART, FLUSH, FLCT, HALT
  } state_t;

  state_t          state, state_n;
  logic [WIDX-1:0] wcnt, wcnt_n;
  logic            miss, xfer, at_last;
  logic            dren_n, dwen_n, last_n, invalid_n;
  logic            flctup_n, flushing_n, idle_n, halt_n;

  assign miss    = (dmemREN | dmemWEN) & ~dhit;
  assign xfer    = (dREN | dWEN) & ~dwait;
  assign at_last = (wcnt == LAST_IDX);

  // Next state, next word count, and next registered outputs
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (miss && !ccwait)       state_n = dirty ? WB : READ;
        else if (flush)            state_n = FLSTART;
        else if (ccwait && ccwrite) state_n = SNOOP;
      end
      WB:      if (xfer && at_last) state_n = READ;
      READ:    if (xfer && at_last) state_n = WAIT;
      SNOOP:   if (xfer && at_last) state_n = WAIT;
      WAIT:    if (!ccwait)         state_n = IDLE;
      FLSTART: begin
        if (flctout == FL_END) state_n = HALT;
        else if (dirty)        state_n = FLUSH;
        else                   state_n = FLCT;
      end
      FLUSH:   if (xfer && at_last) state_n = FLCT;
      FLCT:    state_n = FLSTART;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase

    // Count wraps to 0 on the final word, so it is 0 between bursts
    wcnt_n = wcnt;
    if (state_n != state &&
        (state_n == WB || state_n == READ || state_n == SNOOP || state_n == FLUSH))
      wcnt_n = '0;
    else if (xfer)
      wcnt_n = wcnt + WIDX'(1);

    dren_n     = (state_n == READ);
    dwen_n     = (state_n == WB) || (state_n == SNOOP) || (state_n == FLUSH);
    last_n     = (dren_n || dwen_n) && (wcnt_n == LAST_IDX);
    invalid_n  = dwen_n && last_n;
    flctup_n   = (state_n == FLCT);
    flushing_n = (state_n == FLSTART) || (state_n == FLUSH) || (state_n == FLCT);
    idle_n     = (state_n == IDLE);
    halt_n     = (state_n == HALT);
  end

  // State, counter and output registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      wcnt      <= '0;
      dREN      <= 1'b0;
      dWEN      <= 1'b0;
      last_word <= 1'b0;
      invalid   <= 1'b0;
      flctup    <= 1'b0;
      flushing  <= 1'b0;
      idle      <= 1'b1;
      halt      <= 1'b0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      dREN      <= dren_n;
      dWEN      <= dwen_n;
      last_word <= last_n;
      invalid   <= invalid_n;
      flctup    <= flctup_n;
      flushing  <= flushing_n;
      idle      <= idle_n;
      halt      <= halt_n;
    end
  end

  assign word_idx = wcnt;

  // Final fill word is accepted in the same cycle memory drops dwait
  assign fill_done = dREN & last_word & ~dwait;

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// tb_dcache_ctrl_fsm: directed bench for dcache_ctrl_fsm. Two instances share the
// stimulus: u_dut2 (2-word blocks) and u_dut8 (8-word blocks); each scenario checks
// the instance it targets. A small model of the datapath flush counter feeds flctout.
module tb_dcache_ctrl_fsm;

  logic       CLK, nRST;
  logic       dirty, dirty_drv, flush_mode;
  logic       dhit, dwait, dmemREN, dmemWEN, flush, ccwait, ccwrite;
  logic [4:0] flctout;

  logic       d2_dren, d2_dwen, d2_last, d2_inv, d2_fd, d2_flctup, d2_flushing, d2_idle, d2_halt;
  logic [0:0] d2_idx;
  logic       d8_dren, d8_dwen, d8_last, d8_inv, d8_fd, d8_flctup, d8_flushing, d8_idle, d8_halt;
  logic [2:0] d8_idx;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_ctrl_fsm #(.BLKWORDS(2), .FLUSHLINES(16)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .dirty(dirty), .dhit(dhit), .dwait(dwait),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .flush(flush), .ccwait(ccwait),
    .ccwrite(ccwrite), .flctout(flctout), .dREN(d2_dren), .dWEN(d2_dwen),
    .word_idx(d2_idx), .last_word(d2_last), .invalid(d2_inv), .fill_done(d2_fd),
    .flctup(d2_flctup), .flushing(d2_flushing), .idle(d2_idle), .halt(d2_halt)
  );

  dcache_ctrl_fsm #(.BLKWORDS(8), .FLUSHLINES(16)) u_dut8 (
    .CLK(CLK), .nRST(nRST), .dirty(dirty), .dhit(dhit), .dwait(dwait),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .flush(flush), .ccwait(ccwait),
    .ccwrite(ccwrite), .flctout(flctout), .dREN(d8_dren), .dWEN(d8_dwen),
    .word_idx(d8_idx), .last_word(d8_last), .invalid(d8_inv), .fill_done(d8_fd),
    .flctup(d8_flctup), .flushing(d8_flushing), .idle(d8_idle), .halt(d8_halt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Datapath flush-frame counter model, advanced by u_dut2
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          flctout <= '0;
    else if (d2_flctup) flctout <= flctout + 5'd1;
  end

  // During the flush walk only frames 3 and 9 are dirty
  assign dirty = flush_mode ? (flctout == 5'd3 || flctout == 5'd9) : dirty_drv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int n_up, n_words;

  initial begin
    nRST = 1'b0; dirty_drv = 1'b0; flush_mode = 1'b0; dhit = 1'b1; dwait = 1'b0;
    dmemREN = 1'b0; dmemWEN = 1'b0; flush = 1'b0; ccwait = 1'b0; ccwrite = 1'b0;
    #12;
    check("rst_idle",  32'(d2_idle), 1);
    check("rst_idx",   32'(d2_idx), 0);
    check("rst_dren",  32'(d2_dren), 0);
    check("rst_dwen",  32'(d2_dwen), 0);
    check("rst_halt",  32'(d2_halt), 0);
    check("rst_flush", 32'(d2_flushing), 0);
    tick();
    nRST = 1'b1;
    tick();

    // 1. Clean read miss, 2-word block
    dmemREN = 1'b1; dhit = 1'b0;
    check("t1_idle0", 32'(d2_idle), 1);
    tick();
    dmemREN = 1'b0;
    check("t1_r0_dren", 32'(d2_dren), 1);
    check("t1_r0_idx",  32'(d2_idx), 0);
    check("t1_r0_last", 32'(d2_last), 0);
    check("t1_r0_fd",   32'(d2_fd), 0);
    tick();
    check("t1_r1_idx",  32'(d2_idx), 1);
    check("t1_r1_last", 32'(d2_last), 1);
    check("t1_r1_fd",   32'(d2_fd), 1);
    tick();
    check("t1_wait_dren", 32'(d2_dren), 0);
    check("t1_wait_idle", 32'(d2_idle), 0);
    check("t1_wait_fd",   32'(d2_fd), 0);
    tick();
    check("t1_idle", 32'(d2_idle), 1);

    // 2. Dirty write miss with 3 stall cycles on each word
    dmemWEN = 1'b1; dirty_drv = 1'b1; dwait = 1'b1;
    tick();
    dmemWEN = 1'b0; dirty_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_w0_dwen", 32'(d2_dwen), 1);
      check("t2_w0_idx",  32'(d2_idx), 0);
      check("t2_w0_inv",  32'(d2_inv), 0);
      tick();
    end
    dwait = 1'b0;
    check("t2_w0_go", 32'(d2_idx), 0);
    tick();
    dwait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_w1_dwen", 32'(d2_dwen), 1);
      check("t2_w1_idx",  32'(d2_idx), 1);
      check("t2_w1_inv",  32'(d2_inv), 1);
      check("t2_w1_dren", 32'(d2_dren), 0);
      tick();
    end
    dwait = 1'b0;
    tick();
    check("t2_r0_dren", 32'(d2_dren), 1);
    check("t2_r0_dwen", 32'(d2_dwen), 0);
    check("t2_r0_idx",  32'(d2_idx), 0);
    check("t2_r0_inv",  32'(d2_inv), 0);
    tick();
    check("t2_r1_idx", 32'(d2_idx), 1);
    check("t2_r1_fd",  32'(d2_fd), 1);
    tick();
    tick();
    check("t2_idle", 32'(d2_idle), 1);

    // 3. Snoop while idle; a miss under ccwait is not taken
    ccwait = 1'b1; ccwrite = 1'b0; dmemREN = 1'b1;
    tick();
    check("t3_hold_idle", 32'(d2_idle), 1);
    check("t3_hold_dren", 32'(d2_dren), 0);
    ccwrite = 1'b1;
    tick();
    check("t3_s0_dwen", 32'(d2_dwen), 1);
    check("t3_s0_idx",  32'(d2_idx), 0);
    check("t3_s0_inv",  32'(d2_inv), 0);
    tick();
    check("t3_s1_idx", 32'(d2_idx), 1);
    check("t3_s1_inv", 32'(d2_inv), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t3_wait_idle", 32'(d2_idle), 0);
      check("t3_wait_dwen", 32'(d2_dwen), 0);
      check("t3_wait_dren", 32'(d2_dren), 0);
      tick();
    end
    ccwait = 1'b0; ccwrite = 1'b0; dmemREN = 1'b0;
    tick();
    check("t3_idle", 32'(d2_idle), 1);

    // 5. 8-word block: dirty miss, write-back then fill
    dmemREN = 1'b1; dirty_drv = 1'b1;
    tick();
    dmemREN = 1'b0; dirty_drv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5_wb_dwen", 32'(d8_dwen), 1);
      check("t5_wb_idx",  32'(d8_idx), 32'(i));
      check("t5_wb_last", 32'(d8_last), (i == 7) ? 1 : 0);
      check("t5_wb_inv",  32'(d8_inv),  (i == 7) ? 1 : 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      check("t5_rd_dren", 32'(d8_dren), 1);
      check("t5_rd_dwen", 32'(d8_dwen), 0);
      check("t5_rd_idx",  32'(d8_idx), 32'(i));
      check("t5_rd_last", 32'(d8_last), (i == 7) ? 1 : 0);
      check("t5_rd_fd",   32'(d8_fd),   (i == 7) ? 1 : 0);
      tick();
    end
    check("t5_wait_idle", 32'(d8_idle), 0);
    tick();
    check("t5_idle", 32'(d8_idle), 1);

    // 6. Reset in the middle of an 8-word read
    dmemREN = 1'b1;
    tick();
    dmemREN = 1'b0;
    tick();
    tick();
    check("t6_pre_idx",  32'(d8_idx), 2);
    check("t6_pre_dren", 32'(d8_dren), 1);
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_idle", 32'(d8_idle), 1);
    check("t6_rst_idx",  32'(d8_idx), 0);
    check("t6_rst_dren", 32'(d8_dren), 0);
    tick();
    nRST = 1'b1;
    dmemREN = 1'b1;
    tick();
    dmemREN = 1'b0;
    check("t6_re_dren", 32'(d8_dren), 1);
    check("t6_re_idx",  32'(d8_idx), 0);
    tick();
    check("t6_re_idx1", 32'(d8_idx), 1);
    repeat (8) tick();
    check("t6_re_idle", 32'(d8_idle), 1);
    dhit = 1'b1;

    // 4. Flush walk over 16 frames, frames 3 and 9 dirty
    flush_mode = 1'b1; flush = 1'b1;
    n_up = 0; n_words = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (d2_flctup) n_up++;
      if (d2_dwen && !dwait) n_words++;
      if (d2_dren) check("t4_no_dren", 32'(d2_dren), 0);
      if (d2_halt) break;
    end
    check("t4_flctup_cnt", 32'(n_up), 16);
    check("t4_dwen_words", 32'(n_words), 4);
    check("t4_halt",       32'(d2_halt), 1);
    check("t4_flctout",    32'(flctout), 16);
    check("t4_flushing",   32'(d2_flushing), 0);
    flush = 1'b0; dhit = 1'b0; dmemREN = 1'b1; ccwait = 1'b1; ccwrite = 1'b1;
    repeat (4) tick();
    check("t4_halt_sticky", 32'(d2_halt), 1);
    check("t4_halt_idle",   32'(d2_idle), 0);
    check("t4_halt_dwen",   32'(d2_dwen), 0);
    check("t4_halt_dren",   32'(d2_dren), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
